// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for DIV, DIVU, REM and REMU.
// Restoring shift-subtract datapath that retires one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved on the accepting edge and
// bypass the iteration entirely.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request a division, sampled only while idle
//   op        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   rs1 value, captured on the accepting edge
//   divisor   in   rs2 value, captured on the accepting edge
//   flush     in   synchronous abort, drops any operation in flight
//   busy      out  high from the cycle after acceptance until done
//   done      out  one-cycle pulse, result valid in that cycle
//   result    out  quotient or remainder, held until the next done
//
// state  | meaning
// IDLE   | waiting for start; special cases answered here directly
// CALC   | one shift-subtract iteration per cycle, XLEN cycles
// FIX    | select quotient/remainder, apply sign correction, pulse done
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t          state;
    logic            rem_sel;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;

    // Operand decode for the accepting edge.
    logic            is_signed;
    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign is_signed = ~op[0];
    assign dvd_neg   = is_signed & dividend[XLEN-1];
    assign dvs_neg   = is_signed & divisor[XLEN-1];
    assign dvd_mag   = dvd_neg ? -dividend : dividend;
    assign dvs_mag   = dvs_neg ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
    assign special   = div_zero | ovf;

    // Overflow: the quotient equals the dividend (most negative value) and the
    // remainder is zero. Divide by zero: all ones, or the dividend unchanged.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? dividend : '1;
        else
            special_res = op[1] ? '0 : dividend;
    end

    // The partial remainder is 33 bits wide only after the shift; the stored
    // value is always below the divisor and fits in XLEN bits.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;

    assign rem_sh = {rem, quo[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dvsr    <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            rem_sel <= op[1];
                            neg_q   <= dvd_neg ^ dvs_neg;
                            neg_r   <= dvd_neg;
                            dvsr    <= dvs_mag;
                            quo     <= dvd_mag;
                            rem     <= '0;
                            cnt     <= '0;
                            if (special) begin
                                result <= special_res;
                                done   <= 1'b1;
                            end else begin
                                state <= S_CALC;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    S_CALC: begin
                        if (!trial[XLEN]) begin
                            rem <= trial[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        if (rem_sel)
                            result <= neg_r ? -rem : rem;
                        else
                            result <= neg_q ? -quo : quo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction semantics.
    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Transaction-level timing model: accepted work finishes 33 edges later.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                m_busy = 1'b0; m_left = 0;
            end else if (!m_busy) begin
                if (start) begin
                    if (is_special(op, dividend, divisor)) begin
                        m_result = ref_op(op, dividend, divisor);
                        m_done = 1'b1;
                    end else begin
                        m_pend = ref_op(op, dividend, divisor);
                        m_busy = 1'b1;
                        m_left = 33;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_result = m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("result", result, m_result);
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int intrude);
        int lat;
        logic saw_busy;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
        lat = 1;
        saw_busy = busy;
        while (!done && lat < 40) begin
            if (lat == intrude) begin
                start = 1'b1; op = 2'($urandom); dividend = $urandom; divisor = $urandom_range(1, 9);
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            saw_busy |= busy;
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " latency"}, lat, exp_lat);
        check({name, " value"}, result, exp);
        if (exp_lat == 1) check({name, " busy_seen"}, {31'd0, saw_busy}, 32'd0);
    endtask

    initial begin
        int n_done;
        logic [31:0] saved;

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
        run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
        run_op("divu intrude", 2'b01, 32'd100, 32'd7, 32'd14, 34, 6);

        // Flush mid-operation.
        saved = result;
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("flush no done", n_done, 0);
        check("flush result held", result, saved);
        run_op("divu 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 0);

        // Reset mid-calculation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst no done", n_done, 0);

        // Randomized traffic with stray starts and occasional flushes.
        for (int i = 0; i < 200; i++) begin
            int kind;
            int c;
            logic [31:0] a, b;
            kind = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (kind == 0) b = 32'd0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
            else if (kind == 3) b = $urandom_range(1, 5) | ($urandom_range(0, 1) ? 32'hFFFF_FFF0 : 32'd0);
            @(negedge clk);
            start = 1'b1; op = 2'($urandom); dividend = a; divisor = b;
            flush = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            dividend = $urandom; divisor = $urandom;
            for (c = 0; c < 80; c++) begin
                if (!m_busy) break;
                start = ($urandom_range(0, 9) == 0);
                op = 2'($urandom);
                flush = ($urandom_range(0, 59) == 0);
                @(negedge clk);
                start = 1'b0; flush = 1'b0;
            end
            if (c >= 80) check("random timeout", 32'd1, 32'd0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
